clk_tick_monitor: RTL and testbench

CLK_TICK_MONITOR -- requirements
Module: clk_tick_monitor

---
 rtl/clk_mon_pkg.sv | 20 ++
 rtl/clk_tick_monitor_sync_edge.sv | 26 ++
 rtl/clk_tick_monitor.sv | 132 +++++++++++++
 tb/tb_clk_tick_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the slow-clock tick monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_RANGE   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int DEF_CNT_W      = 20;
  localparam int DEF_EXP_PERIOD = 250002;
  localparam int DEF_TOL        = 16;
  localparam int DEF_LOCK_N     = 4;

endpackage

// File: rtl/clk_tick_monitor_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus an edge register.
// rise is a one-cycle strobe decoded from flopped state only.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_tick_monitor.sv
// Ticks once per slow_clk rising edge, measures its period in clk cycles and tracks
// acquisition, lock and a sticky, clearable fault (out-of-range period or timeout).
module clk_tick_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_N     = DEF_LOCK_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             clr_fault,
  output logic             tick,
  output logic [CNT_W-1:0] period_q,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_cause
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  // One spare bit so P +/- TOL and 2*EXP_PERIOD never wrap.
  localparam logic [CNT_W:0] EXP_X = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0] TOL_X = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0] TMO_X = (CNT_W+1)'(2 * EXP_PERIOD);

  state_e              state_q, state_d;
  logic                tick_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [GOOD_W-1:0]   good_inc;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W:0]      cnt_ext;
  logic                rise, in_range, timeout;

  sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (slow_clk),
    .rise     (rise)
  );

  assign cnt_ext  = {1'b0, cnt_q};
  assign in_range = (cnt_ext + TOL_X >= EXP_X) && (cnt_ext <= EXP_X + TOL_X);
  assign timeout  = (cnt_ext >= TMO_X);
  assign good_inc = good_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    cause_d  = cause_q;
    period_d = period_q;
    if (tick_q)          cnt_d = CNT_W'(1);
    else if (&cnt_q)     cnt_d = cnt_q;
    else                 cnt_d = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick_q) begin
          state_d = ST_ACQ;
          good_d  = '0;
        end else if (timeout) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_ACQ: begin
        if (tick_q) begin
          period_d = cnt_q;
          if (in_range) begin
            good_d = good_inc;
            if (good_inc >= GOOD_W'(LOCK_N)) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_LOCKED: begin
        if (tick_q) begin
          period_d = cnt_q;
          if (!in_range) begin
            state_d = ST_FAULT;
            cause_d = CAUSE_RANGE;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_FAULT: begin
        if (tick_q) period_d = cnt_q;
        // A coincident edge is dropped: the counter restarts from zero, not one.
        if (clr_fault) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
          good_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
      good_q   <= '0;
      cause_q  <= CAUSE_NONE;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= rise;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      cause_q  <= cause_d;
      period_q <= period_d;
    end
  end

  assign tick        = tick_q;
  assign locked      = (state_q == ST_LOCKED);
  assign fault       = (state_q == ST_FAULT);
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_clk_tick_monitor.sv
// Bench for clk_tick_monitor: table of slow_clk phases with hand-derived end results,
// timing corner sequences, and randomized phases checked cycle by cycle against a model.
module tb_clk_tick_monitor;

  localparam int EXP  = 10;
  localparam int TOLR = 1;
  localparam int LOCKN = 4;
  localparam int PMAX = 255;
  localparam int HN   = 8192;

  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_FAULT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       slow_clk;
  logic       clr_fault;
  logic       tick;
  logic [7:0] period_q;
  logic       locked;
  logic       fault;
  logic [1:0] fault_cause;

  clk_tick_monitor #(
    .CNT_W(8), .EXP_PERIOD(EXP), .TOL(TOLR), .LOCK_N(LOCKN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk    (slow_clk),
    .clr_fault   (clr_fault),
    .tick        (tick),
    .period_q    (period_q),
    .locked      (locked),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: time-stamp based, n counts clk edges since reset release.
  int n;
  int ref_t;
  int last_tick_n;
  int m_state, m_good, m_cause, m_period;
  bit hist [HN];

  typedef struct {
    int   p;          // slow_clk period; 0 = hold low for k cycles
    int   k;          // rising edges (or idle cycles when p == 0)
    bit   clr_first;  // assert clr_fault on first tick (or first idle cycle)
    bit   e_locked;
    bit   e_fault;
    int   e_cause;
    int   e_period;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit sv(input int k);
    if (k <= 0 || k >= HN) return 1'b0;
    return hist[k];
  endfunction

  // tick rises on the third clk edge after slow_clk is first sampled high
  function automatic bit exp_tick(input int m);
    return sv(m - 2) & ~sv(m - 3);
  endfunction

  function automatic bit ok_period(input int p);
    return (p - EXP <= TOLR) && (EXP - p <= TOLR);
  endfunction

  task automatic model_reset();
    n = 0; ref_t = 0; last_tick_n = -100;
    m_state = M_IDLE; m_good = 0; m_cause = 0; m_period = 0;
  endtask

  task automatic model_update(input bit c);
    bit tk;
    int el;
    int p;
    tk = exp_tick(n);
    el = n - ref_t;
    p  = (el > PMAX) ? PMAX : el;
    if (m_state == M_FAULT) begin
      if (tk) m_period = p;
      if (c) begin
        m_state = M_IDLE; m_cause = 0; m_good = 0; ref_t = n + 1;
      end else if (tk) begin
        ref_t = n;
      end
    end else if (tk) begin
      ref_t = n;
      if (m_state == M_IDLE) begin
        m_state = M_ACQ; m_good = 0;
      end else begin
        m_period = p;
        if (m_state == M_ACQ) begin
          if (ok_period(p)) begin
            m_good++;
            if (m_good >= LOCKN) m_state = M_LOCKED;
          end else begin
            m_good = 0;
          end
        end else if (!ok_period(p)) begin
          m_state = M_FAULT; m_cause = 1;
        end
      end
    end else if (el >= 2 * EXP) begin
      m_state = M_FAULT; m_cause = 2;
    end
  endtask

  // Called at a negedge: check this cycle's outputs, drive inputs, advance one clk.
  task automatic step(input bit s, input bit c);
    chk("tick", tick, exp_tick(n));
    chk("period_q", period_q, m_period);
    chk("locked", locked, m_state == M_LOCKED);
    chk("fault", fault, m_state == M_FAULT);
    chk("fault_cause", fault_cause, m_cause);
    if (exp_tick(n)) last_tick_n = n;
    slow_clk  = s;
    clr_fault = c;
    if (n + 1 < HN) hist[n + 1] = s;
    model_update(c);
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic phase(input int p, input int k, input bit clr_first);
    bit pend;
    pend = clr_first;
    if (p == 0) begin
      for (int i = 0; i < k; i++) begin
        step(1'b0, pend);
        pend = 1'b0;
      end
    end else begin
      for (int e = 0; e < k; e++) begin
        for (int i = 0; i < p; i++) begin
          bit c;
          c = 1'b0;
          if (pend && exp_tick(n)) begin
            c = 1'b1;
            pend = 1'b0;
          end
          step(i < p / 2, c);
        end
      end
    end
    clr_fault = 1'b0;
  endtask

  task automatic chk_out(input string nm, input bit l, input bit f, input int c, input int p);
    chk({nm, ".locked"}, locked, l);
    chk({nm, ".fault"}, fault, f);
    chk({nm, ".cause"}, fault_cause, c);
    chk({nm, ".period"}, period_q, p);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("arst.tick", tick, 0);
    chk_out("arst", 1'b0, 1'b0, 0, 0);
    slow_clk = 1'b0;
    clr_fault = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{10, 5, 1'b0, 1'b1, 1'b0, 0, 10};  // lock after 5th tick
    vecs[1]  = '{ 9, 2, 1'b0, 1'b1, 1'b0, 0,  9};  // lower tolerance edge
    vecs[2]  = '{11, 2, 1'b0, 1'b1, 1'b0, 0, 11};  // upper tolerance edge
    vecs[3]  = '{12, 2, 1'b0, 1'b0, 1'b1, 1, 12};  // out of range
    vecs[4]  = '{10, 2, 1'b0, 1'b0, 1'b1, 1, 10};  // sticky, period still tracked
    vecs[5]  = '{10, 6, 1'b1, 1'b1, 1'b0, 0, 10};  // clear on a tick, relock
    vecs[6]  = '{ 0, 25, 1'b0, 1'b0, 1'b1, 2, 10}; // timeout while locked
    vecs[7]  = '{13, 3, 1'b0, 1'b0, 1'b1, 2, 13};  // first cause kept
    vecs[8]  = '{ 0, 25, 1'b1, 1'b0, 1'b1, 2, 13}; // clear, then IDLE timeout
    vecs[9]  = '{ 0, 1, 1'b1, 1'b0, 1'b0, 0, 13};  // clear without a tick
    vecs[10] = '{10, 6, 1'b0, 1'b1, 1'b0, 0, 10};  // reacquire

    rst = 1'b0;
    slow_clk = 1'b0;
    clr_fault = 1'b0;
    foreach (hist[i]) hist[i] = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset.tick", tick, 0);
    chk_out("reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int v = 0; v < 11; v++) begin
      phase(vecs[v].p, vecs[v].k, vecs[v].clr_first);
      chk_out($sformatf("vec%0d", v), vecs[v].e_locked, vecs[v].e_fault,
              vecs[v].e_cause, vecs[v].e_period);
    end

    // Timeout timing relative to the last tick while locked.
    while (n < last_tick_n + 19) step(1'b0, 1'b0);
    chk("tmo.before", fault, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("tmo.fault", fault, 1);
    chk("tmo.cause", fault_cause, 2);
    chk("tmo.tick", tick, 0);

    // Relock, then reset in the middle of a period.
    step(1'b0, 1'b1);
    phase(10, 6, 1'b0);
    chk("prerst.locked", locked, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    async_reset();
    phase(10, 1, 1'b0);
    chk("postrst.first_period", period_q, 0);
    phase(10, 1, 1'b0);
    chk("postrst.second_period", period_q, 10);

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0)
        phase(0, $urandom_range(12, 30), $urandom_range(0, 1) == 1);
      else
        phase($urandom_range(8, 13), $urandom_range(1, 3), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
